// File: rtl/hdmi_pll_lock_seq.sv
// rtl/hdmi_pll_lock_seq.sv - HDMI x5 PLL reset, lock qualification, timeout/retry sequencer
// Optional status outputs (loss_count, last_retry) are enabled by NEOTANG_PLL_STATUS_EN.
module hdmi_pll_lock_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 2700,
  parameter int MAX_RETRY     = 7
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       hdmi_rst_n,
  output logic       ready,
  output logic       pll_fail,
  output logic [2:0] state
`ifdef NEOTANG_PLL_STATUS_EN
  ,
  output logic [7:0] loss_count,
  output logic [2:0] last_retry
`endif
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          sync1_q, lock_s_q;
  logic          pll_reset_q, pll_reset_d;
  logic          hdmi_rst_n_q, hdmi_rst_n_d;
  logic          ready_q, ready_d;
  logic          pll_fail_q, pll_fail_d;

  // pll_lock is asynchronous to clkin; lock_s_q is the only copy the FSM sees.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_reset_q  <= 1'b1;
      hdmi_rst_n_q <= 1'b0;
      ready_q      <= 1'b0;
      pll_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_reset_q  <= pll_reset_d;
      hdmi_rst_n_q <= hdmi_rst_n_d;
      ready_q      <= ready_d;
      pll_fail_q   <= pll_fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_q + RW'(1);
          cnt_d   = '0;
          state_d = (retry_d == RETRY_LIMIT) ? FAIL : RESET_PLL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the next state so they switch on the same edge as state.
    pll_reset_d  = (state_d == RESET_PLL) || (state_d == FAIL);
    hdmi_rst_n_d = (state_d == RUN);
    ready_d      = (state_d == RUN);
    pll_fail_d   = (state_d == FAIL);
  end

  assign pll_reset  = pll_reset_q;
  assign hdmi_rst_n = hdmi_rst_n_q;
  assign ready      = ready_q;
  assign pll_fail   = pll_fail_q;
  assign state      = state_q;

`ifdef NEOTANG_PLL_STATUS_EN
  logic [7:0] loss_count_q;
  logic [2:0] last_retry_q;

  // On RUN entry retry is about to clear, so the pre-clear value is captured.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      loss_count_q <= 8'd0;
      last_retry_q <= 3'd0;
    end else begin
      if ((state_q == RUN) && (state_d == RESET_PLL) && (loss_count_q != 8'hFF))
        loss_count_q <= loss_count_q + 8'd1;
      if ((state_d == RUN) && (state_q != RUN))
        last_retry_q <= 3'(retry_q);
      else if ((state_d == FAIL) && (state_q != FAIL))
        last_retry_q <= 3'(retry_d);
    end
  end

  assign loss_count = loss_count_q;
  assign last_retry = last_retry_q;
`endif

endmodule
